// File: rtl/hazard_controller_pkg.sv
// pipeline_ctrl_pkg: types and constants shared by the hazard controller
// and the decode-stage control unit.
//   state_e       - hazard sequencer states (RUN, MEM_WAIT)
//   REG_ZERO      - x0 register index (never a real dependency)
//   hazard_e      - resolved hazard class, highest priority wins
//   hazard_select - priority encoder: freeze > mispredict > load-use > jump
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    HZ_NONE       = 3'd0,
    HZ_JUMP       = 3'd1,
    HZ_LOAD_USE   = 3'd2,
    HZ_MISPREDICT = 3'd3,
    HZ_FREEZE     = 3'd4
  } hazard_e;

  function automatic hazard_e hazard_select(input logic freeze,
                                            input logic mispredict,
                                            input logic load_use,
                                            input logic jump_bubble);
    hazard_e hz;
    if (freeze)           hz = HZ_FREEZE;
    else if (mispredict)  hz = HZ_MISPREDICT;
    else if (load_use)    hz = HZ_LOAD_USE;
    else if (jump_bubble) hz = HZ_JUMP;
    else                  hz = HZ_NONE;
    return hz;
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: bundle between the pipeline and the hazard controller.
//   master - pipeline side: drives hazard inputs, receives enables/flushes/stats
//   slave  - hazard controller side
// CNT_W sets the width of the performance counter outputs.
interface hazard_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs2;
  logic             id_jump;
  logic             id_jump_predicted;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_mispredict;
  logic             dmem_req;
  logic             dmem_ready;
  logic             cnt_clear;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, id_jump, id_jump_predicted,
           ex_rd, ex_mem_read, ex_mispredict, dmem_req, dmem_ready, cnt_clear,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, id_jump, id_jump_predicted,
           ex_rd, ex_mem_read, ex_mispredict, dmem_req, dmem_ready, cnt_clear,
    output pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, mem_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_controller_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
//   clk, rst - clock, synchronous active-high reset
//   clr      - synchronous clear, wins over inc
//   inc      - count this cycle
//   q        - current count
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (inc && cnt_q != '1)  cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign q = cnt_q;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline hazard sequencer for the 5-stage core.
// Drives PC / pipeline-register write enables and flushes (combinational,
// same cycle) for data-memory wait, EX mispredict, load-use and unpredicted
// JAL; keeps saturating stall/flush counters and a sticky memory-timeout flag.
//   clk, rst - clock, synchronous active-high reset (forces writes 0, flushes 1)
//   hz       - hazard_controller_if.slave bundle (hazard inputs, controls, stats)
module hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input logic                clk,
  input logic                rst,
  hazard_controller_if.slave hz
);
  localparam int unsigned     TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;

  logic    freeze, load_use, jump_bubble;
  hazard_e hazard;
  logic    pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f;

  always_comb begin
    freeze      = hz.dmem_req & ~hz.dmem_ready;
    load_use    = hz.ex_mem_read & (hz.ex_rd != REG_ZERO) &
                  ((hz.ex_rd == hz.id_rs1) | (hz.id_uses_rs2 & (hz.ex_rd == hz.id_rs2)));
    jump_bubble = hz.id_jump & ~hz.id_jump_predicted;
    hazard      = hazard_select(freeze, hz.ex_mispredict, load_use, jump_bubble);
  end

  // Mealy control outputs
  always_comb begin
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    idex_w  = 1'b1;
    exmem_w = 1'b1;
    ifid_f  = 1'b0;
    idex_f  = 1'b0;
    if (rst) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_w  = 1'b0;
      exmem_w = 1'b0;
      ifid_f  = 1'b1;
      idex_f  = 1'b1;
    end else begin
      unique case (hazard)
        HZ_FREEZE: begin
          pc_w    = 1'b0;
          ifid_w  = 1'b0;
          idex_w  = 1'b0;
          exmem_w = 1'b0;
        end
        HZ_MISPREDICT: begin
          ifid_f = 1'b1;
          idex_f = 1'b1;
        end
        HZ_LOAD_USE: begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          idex_f = 1'b1;
        end
        HZ_JUMP: ifid_f = 1'b1;
        default: ;
      endcase
    end
  end

  // State, wait-length counter and sticky timeout
  always_comb begin
    state_d   = state_q;
    to_cnt_d  = '0;
    timeout_d = timeout_q;
    unique case (state_q)
      RUN: if (freeze) state_d = MEM_WAIT;
      MEM_WAIT: begin
        if (freeze) begin
          to_cnt_d = (to_cnt_q == TO_LIMIT) ? to_cnt_q : to_cnt_q + TO_W'(1);
          if (to_cnt_d == TO_LIMIT) timeout_d = 1'b1;
        end else begin
          // ready arrived or the request was withdrawn
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (hz.cnt_clear),
    .inc (~pc_w),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (hz.cnt_clear),
    .inc (ifid_f | idex_f),
    .q   (flush_cnt)
  );

  assign hz.pc_write     = pc_w;
  assign hz.if_id_write  = ifid_w;
  assign hz.id_ex_write  = idex_w;
  assign hz.ex_mem_write = exmem_w;
  assign hz.if_id_flush  = ifid_f;
  assign hz.id_ex_flush  = idex_f;
  assign hz.mem_timeout  = timeout_q;
  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_events = flush_cnt;
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed-vector bench for hazard_controller
// (TIMEOUT_CYCLES=4, CNT_W=3). Control outputs are packed as
// {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush}.
module tb_hazard_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_controller_if #(.CNT_W(3)) hz();

  hazard_controller #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  localparam logic [5:0] C_NORM = 6'b111100;
  localparam logic [5:0] C_FRZ  = 6'b000000;
  localparam logic [5:0] C_MISP = 6'b111111;
  localparam logic [5:0] C_LU   = 6'b001101;
  localparam logic [5:0] C_JMP  = 6'b111110;
  localparam logic [5:0] C_RST  = 6'b000011;

  logic [5:0] ctl;
  assign ctl = {hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write,
                hz.if_id_flush, hz.id_ex_flush};

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.id_rs1            = 5'd0;
    hz.id_rs2            = 5'd0;
    hz.id_uses_rs2       = 1'b0;
    hz.id_jump           = 1'b0;
    hz.id_jump_predicted = 1'b0;
    hz.ex_rd             = 5'd0;
    hz.ex_mem_read       = 1'b0;
    hz.ex_mispredict     = 1'b0;
    hz.dmem_req          = 1'b0;
    hz.dmem_ready        = 1'b0;
    hz.cnt_clear         = 1'b0;
  endtask

  task automatic set_lu_rs1();
    hz.ex_mem_read = 1'b1;
    hz.ex_rd       = 5'd5;
    hz.id_rs1      = 5'd5;
  endtask

  initial begin
    idle();
    // reset state
    tick(); tick();
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_stall", 32'(hz.stall_cycles), 0);
    chk("rst_flush", 32'(hz.flush_events), 0);
    chk("rst_timeout", 32'(hz.mem_timeout), 0);
    rst = 1'b0;
    #1 chk("idle_ctl", 32'(ctl), 32'(C_NORM));

    // load-use on rs1: one bubble
    tick();
    set_lu_rs1();
    #1 chk("lu_rs1_ctl", 32'(ctl), 32'(C_LU));
    tick();
    idle();
    #1 chk("lu_after_ctl", 32'(ctl), 32'(C_NORM));
    chk("lu_stall", 32'(hz.stall_cycles), 1);
    chk("lu_flush", 32'(hz.flush_events), 1);

    // x0 and unused-rs2 never stall; rs2 match stalls when rs2 is used
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0; hz.id_rs1 = 5'd0;
    #1 chk("lu_x0_ctl", 32'(ctl), 32'(C_NORM));
    hz.ex_rd = 5'd7; hz.id_rs1 = 5'd3; hz.id_rs2 = 5'd7; hz.id_uses_rs2 = 1'b0;
    #1 chk("lu_rs2_unused_ctl", 32'(ctl), 32'(C_NORM));
    hz.id_uses_rs2 = 1'b1;
    #1 chk("lu_rs2_ctl", 32'(ctl), 32'(C_LU));
    tick();
    idle();
    hz.cnt_clear = 1'b1;
    tick();
    idle();
    #1 chk("clr_stall", 32'(hz.stall_cycles), 0);
    chk("clr_flush", 32'(hz.flush_events), 0);

    // freeze masks a concurrent mispredict, which is acted on at ready
    hz.dmem_req = 1'b1; hz.ex_mispredict = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("frz_misp_ctl", 32'(ctl), 32'(C_FRZ));
      tick();
    end
    hz.dmem_ready = 1'b1;
    #1 chk("frz_ready_ctl", 32'(ctl), 32'(C_MISP));
    tick();
    idle();
    #1 chk("frz_done_ctl", 32'(ctl), 32'(C_NORM));
    chk("frz_stall", 32'(hz.stall_cycles), 3);
    chk("frz_flush", 32'(hz.flush_events), 1);

    // priority among mispredict, load-use, jump (combinational only)
    hz.ex_mispredict = 1'b1; set_lu_rs1(); hz.id_jump = 1'b1;
    #1 chk("prio_misp_ctl", 32'(ctl), 32'(C_MISP));
    hz.ex_mispredict = 1'b0;
    #1 chk("prio_lu_ctl", 32'(ctl), 32'(C_LU));
    hz.ex_mem_read = 1'b0;
    #1 chk("jump_ctl", 32'(ctl), 32'(C_JMP));
    hz.id_jump_predicted = 1'b1;
    #1 chk("jump_pred_ctl", 32'(ctl), 32'(C_NORM));
    idle();

    // single-cycle access: no freeze, no stall counted
    hz.dmem_req = 1'b1; hz.dmem_ready = 1'b1;
    #1 chk("single_acc_ctl", 32'(ctl), 32'(C_NORM));
    tick();
    idle();
    #1 chk("single_acc_stall", 32'(hz.stall_cycles), 3);

    // timeout after the 4th MEM_WAIT cycle; stall counter saturates
    hz.dmem_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 chk("to_frz_ctl", 32'(ctl), 32'(C_FRZ));
      tick();
      chk("to_flag", 32'(hz.mem_timeout), (i >= 4) ? 32'd1 : 32'd0);
    end
    hz.dmem_ready = 1'b1;
    #1 chk("to_ready_ctl", 32'(ctl), 32'(C_NORM));
    tick();
    idle();
    #1 chk("to_sticky", 32'(hz.mem_timeout), 1);
    chk("to_stall_sat", 32'(hz.stall_cycles), 7);
    hz.cnt_clear = 1'b1;
    tick();
    idle();
    #1 chk("to_clr_stall", 32'(hz.stall_cycles), 0);
    chk("to_sticky2", 32'(hz.mem_timeout), 1);

    // 10 consecutive load-use stalls saturate at 7; clear beats increment
    set_lu_rs1();
    repeat (10) tick();
    chk("sat_stall", 32'(hz.stall_cycles), 7);
    chk("sat_flush", 32'(hz.flush_events), 7);
    hz.cnt_clear = 1'b1;
    tick();
    idle();
    #1 chk("sat_clr_stall", 32'(hz.stall_cycles), 0);
    chk("sat_clr_flush", 32'(hz.flush_events), 0);

    // reset mid-MEM_WAIT
    hz.dmem_req = 1'b1;
    tick(); tick();
    rst = 1'b1;
    #1 chk("rst_mid_ctl", 32'(ctl), 32'(C_RST));
    tick();
    chk("rst_mid_ctl2", 32'(ctl), 32'(C_RST));
    chk("rst_mid_timeout", 32'(hz.mem_timeout), 0);
    chk("rst_mid_stall", 32'(hz.stall_cycles), 0);
    rst = 1'b0;
    idle();
    #1 chk("rst_rel_ctl", 32'(ctl), 32'(C_NORM));
    hz.dmem_req = 1'b1;
    repeat (3) tick();
    chk("rst_rel_timeout", 32'(hz.mem_timeout), 0);
    chk("rst_rel_stall", 32'(hz.stall_cycles), 3);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
